// File: rtl/brief_keypoint_scheduler.sv
// Keypoint release scheduler: queues raster-ordered keypoints and releases each on the
// cycle the line-buffer window centre reaches it. Optional border filter: BRIEF_BORDER_FILTER_EN.
module brief_keypoint_scheduler #(
  parameter int DEPTH  = 100,
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int RADIUS = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_frame_start,
  input  logic        i_frame_end,
  input  logic        i_flag,
  input  logic [9:0]  i_coor_x,
  input  logic [9:0]  i_coor_y,
  input  logic [11:0] i_sin,
  input  logic [11:0] i_cos,
  input  logic        i_win_valid,
  input  logic [9:0]  i_win_x,
  input  logic [9:0]  i_win_y,
  output logic        o_hit,
  output logic [9:0]  o_coor_x,
  output logic [9:0]  o_coor_y,
  output logic [11:0] o_sin,
  output logic [11:0] o_cos,
  output logic [9:0]  o_count,
  output logic        o_busy,
  output logic        o_done,
  output logic [7:0]  o_miss_cnt,
  output logic [7:0]  o_ovf_cnt,
  output logic [1:0]  o_state
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef BRIEF_BORDER_FILTER_EN
  localparam logic FILTER = 1'b1;
`else
  localparam logic FILTER = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t state, state_next;
  logic   done_next;

  // Entry layout {x, y, sin, cos}; storage needs no reset because the pointers gate it.
  logic [43:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [43:0]   head;
  logic [19:0]   head_key, win_key;
  logic          full, empty, cmp_en, hit_now, pop, stale;
  logic          border_ok, in_border, push_req, push, reject;
  logic [10:0]   drain_sum;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // i_flag is a fire-and-forget strobe with no ready: a push the queue cannot take is
  // dropped and counted; o_hit is a valid-only strobe that BRIEF must always accept.
  always_comb begin
    head      = mem[rd_ptr];
    head_key  = {head[33:24], head[43:34]};
    win_key   = {i_win_y, i_win_x};
    full      = (o_count == 10'(DEPTH));
    empty     = (o_count == 10'd0);
    cmp_en    = (state == ST_RUN) && !empty && i_win_valid && !i_frame_start;
    hit_now   = cmp_en && (head_key == win_key);
    stale     = cmp_en && (head_key < win_key);
    pop       = hit_now || stale;
    border_ok = (i_coor_x >= 10'(RADIUS)) && (i_coor_x <= 10'(WIDTH - 1 - RADIUS)) &&
                (i_coor_y >= 10'(RADIUS)) && (i_coor_y <= 10'(HEIGHT - 1 - RADIUS));
    in_border = !FILTER || border_ok;
    push_req  = (state == ST_RUN) && i_flag && !i_frame_start && in_border;
    push      = push_req && (!full || pop);
    reject    = push_req && full && !pop;
    drain_sum = {3'b000, o_miss_cnt} + {1'b0, o_count};
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    if (i_frame_start) begin
      state_next = ST_RUN;
    end else begin
      case (state)
        ST_IDLE:  state_next = ST_IDLE;
        ST_RUN:   if (i_frame_end) state_next = ST_DRAIN;
        ST_DRAIN: begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {i_coor_x, i_coor_y, i_sin, i_cos};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      o_count    <= '0;
      o_hit      <= 1'b0;
      o_done     <= 1'b0;
      o_coor_x   <= '0;
      o_coor_y   <= '0;
      o_sin      <= '0;
      o_cos      <= '0;
      o_miss_cnt <= '0;
      o_ovf_cnt  <= '0;
    end else begin
      state  <= state_next;
      o_done <= done_next;
      o_hit  <= hit_now;
      if (hit_now) begin
        o_coor_x <= head[43:34];
        o_coor_y <= head[33:24];
        o_sin    <= head[23:12];
        o_cos    <= head[11:0];
      end
      if (i_frame_start) begin
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        o_count    <= '0;
        o_miss_cnt <= '0;
        o_ovf_cnt  <= '0;
      end else if (state == ST_DRAIN) begin
        // Every entry still queued at drain counts as a missed keypoint.
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        o_count    <= '0;
        o_miss_cnt <= (drain_sum > 11'd255) ? 8'd255 : drain_sum[7:0];
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        if (push && !pop)      o_count <= o_count + 10'd1;
        else if (pop && !push) o_count <= o_count - 10'd1;
        if (stale && o_miss_cnt != 8'd255) o_miss_cnt <= o_miss_cnt + 8'd1;
        if (reject && o_ovf_cnt != 8'd255) o_ovf_cnt <= o_ovf_cnt + 8'd1;
      end
    end
  end

  assign o_busy  = (state != ST_IDLE);
  assign o_state = state;

endmodule

// File: tb/tb_brief_keypoint_scheduler.sv
// Bench for brief_keypoint_scheduler: directed scenarios plus random frames, all checked
// each cycle against a queue-based behavioural model of the scheduler.
module tb_brief_keypoint_scheduler;

  localparam int DEPTH  = 4;
  localparam int WIDTH  = 640;
  localparam int HEIGHT = 480;
  localparam int RADIUS = 15;

  logic        clk = 1'b0;
  logic        rst_n, frame_start, frame_end, flag, win_valid;
  logic [9:0]  coor_x, coor_y, win_x, win_y;
  logic [11:0] sin_v, cos_v;
  logic        hit, busy, done;
  logic [9:0]  out_x, out_y, count;
  logic [11:0] out_sin, out_cos;
  logic [7:0]  miss_cnt, ovf_cnt;
  logic [1:0]  dbg_state;

  brief_keypoint_scheduler #(.DEPTH(DEPTH), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .RADIUS(RADIUS)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start), .i_frame_end(frame_end),
    .i_flag(flag), .i_coor_x(coor_x), .i_coor_y(coor_y), .i_sin(sin_v), .i_cos(cos_v),
    .i_win_valid(win_valid), .i_win_x(win_x), .i_win_y(win_y),
    .o_hit(hit), .o_coor_x(out_x), .o_coor_y(out_y), .o_sin(out_sin), .o_cos(out_cos),
    .o_count(count), .o_busy(busy), .o_done(done), .o_miss_cnt(miss_cnt),
    .o_ovf_cnt(ovf_cnt), .o_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [43:0] exp_q[$];
  int          m_mode;
  logic        m_hit, m_done;
  logic [9:0]  m_x, m_y;
  logic [11:0] m_sin, m_cos;
  int          m_miss, m_ovf;
  int          total = 0;
  int          bad = 0;

  function automatic bit in_border(int x, int y);
`ifdef BRIEF_BORDER_FILTER_EN
    return x >= RADIUS && x <= WIDTH - 1 - RADIUS && y >= RADIUS && y <= HEIGHT - 1 - RADIUS;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int sat(int v);
    return (v > 255) ? 255 : v;
  endfunction

  task model_step();
    logic [43:0] h;
    int hk, wk;
    m_hit  = 1'b0;
    m_done = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      m_mode = 0; m_x = '0; m_y = '0; m_sin = '0; m_cos = '0; m_miss = 0; m_ovf = 0;
    end else if (frame_start) begin
      exp_q.delete();
      m_miss = 0; m_ovf = 0; m_mode = 1;
    end else if (m_mode == 1) begin
      if (exp_q.size() > 0 && win_valid) begin
        h  = exp_q[0];
        hk = int'(h[33:24]) * 1024 + int'(h[43:34]);
        wk = int'(win_y) * 1024 + int'(win_x);
        if (hk == wk) begin
          m_hit = 1'b1;
          {m_x, m_y, m_sin, m_cos} = h;
          void'(exp_q.pop_front());
        end else if (hk < wk) begin
          m_miss = sat(m_miss + 1);
          void'(exp_q.pop_front());
        end
      end
      if (flag && in_border(int'(coor_x), int'(coor_y))) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({coor_x, coor_y, sin_v, cos_v});
        else m_ovf = sat(m_ovf + 1);
      end
      if (frame_end) m_mode = 2;
    end else if (m_mode == 2) begin
      m_miss = sat(m_miss + exp_q.size());
      exp_q.delete();
      m_mode = 0;
      m_done = 1'b1;
    end
  endtask

  // ---------------- checking ----------------
  task check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task check_all();
    check("hit", 32'(hit), 32'(m_hit));
    check("out_x", 32'(out_x), 32'(m_x));
    check("out_y", 32'(out_y), 32'(m_y));
    check("out_sin", 32'(out_sin), 32'(m_sin));
    check("out_cos", 32'(out_cos), 32'(m_cos));
    check("count", 32'(count), 32'(exp_q.size()));
    check("miss", 32'(miss_cnt), 32'(m_miss));
    check("ovf", 32'(ovf_cnt), 32'(m_ovf));
    check("busy", 32'(busy), 32'(m_mode != 0));
    check("done", 32'(done), 32'(m_done));
  endtask

  // ---------------- driver tasks ----------------
  task tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task clear_inputs();
    frame_start = 0; frame_end = 0; flag = 0; win_valid = 0;
  endtask

  task push_kp(input int x, input int y, input int s, input int c);
    flag = 1; coor_x = 10'(x); coor_y = 10'(y); sin_v = 12'(s); cos_v = 12'(c);
    tick();
    flag = 0;
  endtask

  task show_win(input int x, input int y);
    win_valid = 1; win_x = 10'(x); win_y = 10'(y);
    tick();
    win_valid = 0;
  endtask

  task pulse_start();
    frame_start = 1; tick(); frame_start = 0;
  endtask

  task pulse_end();
    frame_end = 1; tick(); frame_end = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wpos, kpos, exp_cnt;
    rst_n = 0; clear_inputs();
    coor_x = '0; coor_y = '0; sin_v = '0; cos_v = '0; win_x = '0; win_y = '0;
    tick(); tick();
    check("reset_count", 32'(count), 32'd0);
    check("reset_hit", 32'(hit), 32'd0);
    rst_n = 1;
    tick();

    // single keypoint, released one cycle after its window
    pulse_start();
    push_kp(20, 20, 0, 12'h7FF);
    tick();
    show_win(20, 20);
    check("single_hit", 32'(hit), 32'd1);
    check("single_x", 32'(out_x), 32'd20);
    check("single_y", 32'(out_y), 32'd20);
    check("single_cos", 32'(out_cos), 32'h7FF);
    check("single_count", 32'(count), 32'd0);
    tick();
    check("single_hit_gone", 32'(hit), 32'd0);

    // back-to-back hits in push order
    push_kp(30, 20, 12'h123, 12'h456);
    push_kp(31, 20, 12'hABC, 12'h321);
    show_win(30, 20);
    check("b2b_first", 32'(out_x), 32'd30);
    show_win(31, 20);
    check("b2b_second_hit", 32'(hit), 32'd1);
    check("b2b_second", 32'(out_x), 32'd31);

    // stale keypoint dropped
    pulse_start();
    push_kp(10, 16, 1, 2);
    show_win(50, 16);
    check("stale_miss", 32'(miss_cnt), in_border(10, 16) ? 32'd1 : 32'd0);
    check("stale_count", 32'(count), 32'd0);

    // overflow and saturation
    pulse_start();
    for (int i = 0; i < 6; i++) push_kp(100 + i, 100, i, i);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_two", 32'(ovf_cnt), 32'd2);
    for (int i = 0; i < 300; i++) push_kp(200, 200, i, i);
    check("ovf_sat", 32'(ovf_cnt), 32'd255);

    // drain discards queued entries
    pulse_start();
    for (int i = 0; i < 3; i++) push_kp(100 + i, 50, i, i);
    pulse_end();
    check("drain_busy", 32'(busy), 32'd1);
    tick();
    check("drain_done", 32'(done), 32'd1);
    check("drain_miss", 32'(miss_cnt), 32'd3);
    check("drain_count", 32'(count), 32'd0);
    check("drain_idle", 32'(busy), 32'd0);
    tick();
    check("done_once", 32'(done), 32'd0);

    // border keypoints
    pulse_start();
    push_kp(5, 100, 0, 0);
    push_kp(100, 470, 0, 0);
    exp_cnt = (in_border(5, 100) ? 1 : 0) + (in_border(100, 470) ? 1 : 0);
    check("border_count", 32'(count), 32'(exp_cnt));
    pulse_end();
    tick();

    // random frames
    for (int f = 0; f < 6; f++) begin
      pulse_start();
      wpos = 14 * WIDTH + $urandom_range(0, 40);
      kpos = wpos;
      for (int c = 0; c < 150; c++) begin
        flag = ($urandom_range(0, 2) == 0);
        if (flag) begin
          kpos = wpos + $urandom_range(0, 12) - 3;
          if (kpos <= int'(coor_y) * WIDTH + int'(coor_x)) kpos = int'(coor_y) * WIDTH + int'(coor_x) + 1;
          coor_x = 10'(kpos % WIDTH); coor_y = 10'(kpos / WIDTH);
          sin_v = 12'($urandom); cos_v = 12'($urandom);
        end
        win_valid = ($urandom_range(0, 3) != 0);
        win_x = 10'(wpos % WIDTH); win_y = 10'(wpos / WIDTH);
        rst_n = !(f == 3 && c == 80);
        tick();
        if (win_valid) wpos++;
        rst_n = 1;
      end
      clear_inputs();
      pulse_end();
      tick();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/brief_keypoint_scheduler.md
Name: brief_keypoint_scheduler

Overview:
Sequences keypoints from the orientation stage into the BRIEF descriptor unit. Keypoints (x, y, sin, cos) arrive in raster order and are held in a circular queue. Each keypoint is released as a one-cycle hit, with its fields, on the cycle the streaming line-buffer window centre reaches its coordinate. Keypoints the window has already passed are dropped. Per-frame start, drain and done sequencing plus saturating diagnostic counters are included.

Parameters:
DEPTH, 100, queue entries (2..1023)
WIDTH, 640, frame width in pixels
HEIGHT, 480, frame height in pixels
RADIUS, 15, descriptor patch half-size, used by the border filter

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst_n  in  1  synchronous active-low reset
i_frame_start  in  1  pulse: new frame; flushes queue and enters RUN
i_frame_end  in  1  pulse: last window of frame presented; enters DRAIN
i_flag  in  1  keypoint push strobe
i_coor_x  in  10  keypoint x
i_coor_y  in  10  keypoint y
i_sin  in  12  keypoint orientation sine (two's complement)
i_cos  in  12  keypoint orientation cosine
i_win_valid  in  1  window centre below is valid this cycle
i_win_x  in  10  current window centre x
i_win_y  in  10  current window centre y
o_hit  out  1  one-cycle release strobe to BRIEF
o_coor_x  out  10  released keypoint x
o_coor_y  out  10  released keypoint y
o_sin  out  12  released sine
o_cos  out  12  released cosine
o_count  out  10  queue occupancy
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle pulse at end of DRAIN
o_miss_cnt  out  8  stale keypoints dropped this frame, saturates at 255
o_ovf_cnt  out  8  pushes rejected while full this frame, saturates at 255

Behaviour:
- Reset (i_rst_n low at a clock edge): state IDLE; queue empty (rd/wr pointers 0, o_count 0); all outputs 0.
- States:
  - IDLE: i_frame_start -> RUN.
  - RUN: i_frame_end -> DRAIN.
  - DRAIN: always -> IDLE after 1 cycle; o_done = 1 on that transition.
  - i_frame_start in any state: flush queue, clear both counters, -> RUN. Takes priority over i_frame_end and i_flag in the same cycle.
- Push, in RUN only; ignored in IDLE and DRAIN:
  - On i_flag, write {x, y, sin, cos} at wr_ptr. Pointer wraps DEPTH-1 -> 0.
  - Full and no pop this cycle: push rejected, o_ovf_cnt +1 (saturating).
  - Full with a pop this cycle: push accepted, occupancy unchanged.
- Head compare: RUN, queue non-empty, i_win_valid = 1. Order by raster key (y, x), y major.
  - Head key == window key: pop; next cycle o_hit = 1 and o_coor_x/o_coor_y/o_sin/o_cos = head fields.
  - Head key < window key: pop with no hit; o_miss_cnt +1 (saturating).
  - Head key > window key: hold.
  - At most one pop per cycle.
  - Push to an empty queue is not visible to the compare until the following cycle; no bypass.
- Latency: matching window presented at cycle N -> o_hit at N+1. Back-to-back hits are allowed on consecutive cycles.
- Output fields hold their last released values while o_hit = 0.
- DRAIN: remaining entries are discarded; each adds 1 to o_miss_cnt (saturating); queue empty at exit.
- o_count: 0..DEPTH; updates the cycle after push/pop. Simultaneous push and pop leaves it unchanged.
- Counters hold their value after the frame until the next i_frame_start or reset.
- Mid-frame reset: identical to power-on reset; no o_done is issued.

Optional Feature:
Macro BRIEF_BORDER_FILTER_EN.
- Defined: a push is rejected, with no counter change, if x < RADIUS, x > WIDTH-1-RADIUS, y < RADIUS, or y > HEIGHT-1-RADIUS.
- Undefined: every push is accepted subject to the full condition, and border keypoints are released normally.

Test Plan:
- Reset, frame_start, push (x=20, y=20, sin=0, cos=0x7FF); window steps to (20, 20) -> o_hit = 1 exactly one cycle later with x=20, y=20, cos=0x7FF; o_count returns 0.
- Push (30, 20) and (31, 20); window presents (30, 20), then (31, 20) on consecutive cycles -> two consecutive o_hit cycles in push order.
- Push (10, 16); window already at (50, 16) -> no hit; o_miss_cnt = 1; entry popped.
- DEPTH = 4, push 6 keypoints with no window -> o_count = 4, o_ovf_cnt = 2. Then 300 more pushes -> o_ovf_cnt saturates at 255.
- 3 entries queued, frame_end -> DRAIN one cycle, o_done pulse, o_miss_cnt += 3, o_count = 0, o_busy = 0.
- With BRIEF_BORDER_FILTER_EN, push (5, 100) and (100, 470) -> both rejected, o_count = 0. Without the macro -> both accepted, o_count = 2.
